// File: rtl/clk_2m5_monitor.sv
// clk_2m5_monitor
//   Measures the frequency of clk_2M5 by counting its rising edges over a
//   fixed gate of GATE_CYCLES clk_debug cycles.
//   - Each window is classified as too slow, in spec, or too fast.
//   - A lock indication is kept once enough consecutive windows are good.
//   - A loss-of-clock watchdog runs alongside the measurement.
//
// Ports
//   clk_debug  in   sole clock; all logic runs on its rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   synchronous run enable; low forces IDLE and clears run state
//   clk_2M5    in   monitored clock, sampled as asynchronous data
//   edge_count out  edge count of the last completed window
//   meas_valid out  one-cycle strobe when edge_count and the window flags update
//   freq_ok    out  last window within [MIN_EDGES, MAX_EDGES]
//   too_slow   out  last window below MIN_EDGES
//   too_fast   out  last window above MAX_EDGES
//   clk_lost   out  no clk_2M5 edge seen for TIMEOUT cycles
//   locked     out  LOCK_WINDOWS consecutive good windows with no loss event
module clk_2m5_monitor #(
  parameter int unsigned GATE_CYCLES  = 3800,
  parameter int unsigned CNT_W        = 12,
  parameter int unsigned MIN_EDGES    = 240,
  parameter int unsigned MAX_EDGES    = 266,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned LOCK_WINDOWS = 4
) (
  input  logic             clk_debug,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clk_2M5,
  output logic [CNT_W-1:0] edge_count,
  output logic             meas_valid,
  output logic             freq_ok,
  output logic             too_slow,
  output logic             too_fast,
  output logic             clk_lost,
  output logic             locked
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned RUN_W  = $clog2(LOCK_WINDOWS + 1);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_WINDOWS);
  localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_EDGES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_REPORT
  } state_e;

  // Synchronizer and edge detector
  logic sync1_q, sync2_q, sync3_q;
  logic edge_pulse;

  // Control state and counters
  state_e            state_q, state_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  edge_q, edge_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              lost_q, lost_d;

  // Reported results
  logic [CNT_W-1:0]  edge_count_q, edge_count_d;
  logic              meas_valid_q, meas_valid_d;
  logic              freq_ok_q, freq_ok_d;
  logic              too_slow_q, too_slow_d;
  logic              too_fast_q, too_fast_d;

  logic win_slow, win_fast, win_ok;

  // Synchronizer keeps running while disabled so that re-enable sees a settled
  // signal rather than a spurious edge from stale flops.
  always_ff @(posedge clk_debug or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= clk_2M5;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign edge_pulse = sync2_q & ~sync3_q;

  assign win_slow = (edge_q < MIN_CNT);
  assign win_fast = (edge_q > MAX_CNT);
  assign win_ok   = ~win_slow & ~win_fast;

  always_ff @(posedge clk_debug or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      gate_q       <= '0;
      edge_q       <= '0;
      to_q         <= '0;
      run_q        <= '0;
      lost_q       <= 1'b0;
      edge_count_q <= '0;
      meas_valid_q <= 1'b0;
      freq_ok_q    <= 1'b0;
      too_slow_q   <= 1'b0;
      too_fast_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_q       <= gate_d;
      edge_q       <= edge_d;
      to_q         <= to_d;
      run_q        <= run_d;
      lost_q       <= lost_d;
      edge_count_q <= edge_count_d;
      meas_valid_q <= meas_valid_d;
      freq_ok_q    <= freq_ok_d;
      too_slow_q   <= too_slow_d;
      too_fast_q   <= too_fast_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gate_d       = gate_q;
    edge_d       = edge_q;
    to_d         = to_q;
    run_d        = run_q;
    lost_d       = lost_q;
    edge_count_d = edge_count_q;
    meas_valid_d = 1'b0;
    freq_ok_d    = freq_ok_q;
    too_slow_d   = too_slow_q;
    too_fast_d   = too_fast_q;

    if (!enable) begin
      // Abandon any partial window; reported results are left untouched.
      state_d = S_IDLE;
      gate_d  = '0;
      edge_d  = '0;
      to_d    = '0;
      run_d   = '0;
      lost_d  = 1'b0;
    end else begin
      // Loss watchdog
      if (edge_pulse) begin
        to_d   = '0;
        lost_d = 1'b0;
      end else begin
        if (to_q != TO_MAX) begin
          to_d = to_q + 1'b1;
        end
        if (to_q == TO_MAX) begin
          lost_d = 1'b1;
        end
      end

      unique case (state_q)
        S_IDLE: begin
          state_d = S_MEASURE;
          gate_d  = '0;
          edge_d  = '0;
        end

        S_MEASURE: begin
          if (edge_pulse && (edge_q != '1)) begin
            edge_d = edge_q + 1'b1;
          end
          if (gate_q == GATE_LAST) begin
            state_d = S_REPORT;
          end else begin
            gate_d = gate_q + 1'b1;
          end
        end

        S_REPORT: begin
          meas_valid_d = 1'b1;
          edge_count_d = edge_q;
          too_slow_d   = win_slow;
          too_fast_d   = win_fast;
          freq_ok_d    = win_ok;
          // A good window seen while the clock is flagged lost earns no credit.
          if (!win_ok) begin
            run_d = '0;
          end else if (!lost_q && (run_q != RUN_MAX)) begin
            run_d = run_q + 1'b1;
          end
          // Continuous measurement: the REPORT cycle is the first cycle of the
          // next window, so an edge here seeds the new count.
          state_d   = S_MEASURE;
          gate_d    = '0;
          edge_d    = '0;
          edge_d[0] = edge_pulse;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase

      // Asserting (or holding) clk_lost drops any lock progress immediately.
      if (lost_d) begin
        run_d = '0;
      end
    end
  end

  assign edge_count = edge_count_q;
  assign meas_valid = meas_valid_q;
  assign freq_ok    = freq_ok_q;
  assign too_slow   = too_slow_q;
  assign too_fast   = too_fast_q;
  assign clk_lost   = lost_q;
  assign locked     = (run_q == RUN_MAX);

endmodule

// File: tb/tb_clk_2m5_monitor.sv
// Testbench for clk_2m5_monitor.
//   The reference model describes measurement windows as cycle intervals,
//   derives expected reports, and pushes them to a scoreboard queue.
//   A separate monitor pops the queue on every meas_valid and compares.
module tb_clk_2m5_monitor;

  localparam int G    = 3800;
  localparam int CW   = 12;
  localparam int MINE = 240;
  localparam int MAXE = 266;
  localparam int TO   = 64;
  localparam int LW   = 4;
  localparam int WIN  = G + 1;

  logic          clk_debug = 1'b0;
  logic          rst_n     = 1'b0;
  logic          enable    = 1'b0;
  logic          clk_2M5   = 1'b0;
  logic [CW-1:0] edge_count;
  logic          meas_valid, freq_ok, too_slow, too_fast, clk_lost, locked;

  clk_2m5_monitor #(
    .GATE_CYCLES (G),
    .CNT_W       (CW),
    .MIN_EDGES   (MINE),
    .MAX_EDGES   (MAXE),
    .TIMEOUT     (TO),
    .LOCK_WINDOWS(LW)
  ) dut (
    .clk_debug (clk_debug),
    .rst_n     (rst_n),
    .enable    (enable),
    .clk_2M5   (clk_2M5),
    .edge_count(edge_count),
    .meas_valid(meas_valid),
    .freq_ok   (freq_ok),
    .too_slow  (too_slow),
    .too_fast  (too_fast),
    .clk_lost  (clk_lost),
    .locked    (locked)
  );

  always #5 clk_debug = ~clk_debug;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int cnt;
    bit ok;
    bit slow;
    bit fast;
    bit lk;
  } rep_t;

  rep_t sbq[$];

  // ---------------- reference model state ----------------
  int n = 0;          // index of the latest clk_debug rising edge
  int due[$];         // edges at which a synchronized edge pulse is seen
  bit prev_in = 0;
  bit running = 0;
  int report_at = 0;
  int cnt = 0;
  int last_clr = 0;   // last edge at which the idle timer restarted
  int run = 0;
  bit lost_m = 0;
  int h_cnt = 0;
  bit h_ok = 0, h_slow = 0, h_fast = 0;
  bit pulse_m, lost_before, rep_now;
  int c;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, n, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_debug);
      n++;
      rep_now = 0;
      if (!rst_n) begin
        prev_in = 0;
        due.delete();
        running = 0;
        cnt = 0;
        last_clr = n;
        run = 0;
        lost_m = 0;
        h_cnt = 0; h_ok = 0; h_slow = 0; h_fast = 0;
      end else begin
        // An input rise sampled at edge k becomes visible to the counters at k+2.
        pulse_m = (due.size() != 0) && (due[0] == n);
        if (pulse_m) void'(due.pop_front());
        if (clk_2M5 && !prev_in) due.push_back(n + 2);
        prev_in = clk_2M5;
        lost_before = lost_m;
        if (!enable) begin
          running = 0;
          run = 0;
          lost_m = 0;
          last_clr = n;
        end else begin
          lost_m = !pulse_m && ((n - 1 - last_clr) >= TO);
          if (pulse_m) last_clr = n;
          if (!running) begin
            // First window: G counted cycles, report one cycle later.
            running = 1;
            cnt = 0;
            report_at = n + G + 1;
          end else if (n == report_at) begin
            c = (cnt > 4095) ? 4095 : cnt;
            h_cnt  = c;
            h_slow = (c < MINE);
            h_fast = (c > MAXE);
            h_ok   = !h_slow && !h_fast;
            if (!h_ok) run = 0;
            else if (!lost_before && run < LW) run++;
            report_at += WIN;
            cnt = pulse_m ? 1 : 0;
            rep_now = 1;
          end else if (pulse_m) begin
            cnt++;
          end
          if (lost_m) run = 0;
        end
        if (rep_now) sbq.push_back('{n, h_cnt, h_ok, h_slow, h_fast, run == LW});
      end
      #1;
      chk("clk_lost", int'(clk_lost), int'(lost_m));
      chk("locked", int'(locked), int'(run == LW));
      chk("edge_count_hold", int'(edge_count), h_cnt);
      chk("flags_hold", int'({freq_ok, too_slow, too_fast}), int'({h_ok, h_slow, h_fast}));
    end
  end

  // ---------------- scoreboard monitor ----------------
  rep_t e;
  initial begin
    forever begin
      @(posedge clk_debug);
      #1;
      if (meas_valid) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL report_spurious at edge %0d: meas_valid=1 expected 0", n);
        end else begin
          e = sbq.pop_front();
          if (e.cyc != n || int'(edge_count) != e.cnt ||
              {freq_ok, too_slow, too_fast} != {e.ok, e.slow, e.fast} || locked != e.lk) begin
            errors++;
            $display("FAIL report at edge %0d: got cnt=%0d ok/slow/fast=%b%b%b lk=%b expected edge %0d cnt=%0d ok/slow/fast=%b%b%b lk=%b",
                     n, edge_count, freq_ok, too_slow, too_fast, locked,
                     e.cyc, e.cnt, e.ok, e.slow, e.fast, e.lk);
          end
        end
      end else if (sbq.size() != 0 && sbq[0].cyc <= n) begin
        checks++;
        errors++;
        $display("FAIL report_missing at edge %0d: meas_valid=0 expected 1", n);
        void'(sbq.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  int unsigned ph = 0;

  task automatic drive(input int unsigned p, input int unsigned ncyc);
    for (int unsigned i = 0; i < ncyc; i++) begin
      @(negedge clk_debug);
      if (p == 0) begin
        clk_2M5 = 1'b0;
      end else begin
        ph++;
        clk_2M5 = ((ph % p) < (p / 2));
      end
    end
  endtask

  task automatic wait_mv(input int unsigned budget, input int unsigned p);
    int unsigned k;
    k = 0;
    while (!meas_valid && k < budget) begin
      drive(p, 1);
      k++;
    end
    if (!meas_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_meas_valid: no strobe within %0d cycles", budget);
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_edge_count", int'(edge_count), 0);
    chk("rst_meas_valid", int'(meas_valid), 0);
    chk("rst_flags", int'({freq_ok, too_slow, too_fast}), 0);
    chk("rst_clk_lost", int'(clk_lost), 0);
    chk("rst_locked", int'(locked), 0);
  endtask

  int unsigned rp;

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    chk_all_zero();
    drive(0, 3);
    rst_n = 1'b1;
    enable = 1'b1;

    // Nominal clock: lock after four good windows.
    ph = $urandom_range(0, 14);
    drive(15, 5 * WIN + 50);

    // Clock stops, then resumes and re-locks.
    drive(0, 150);
    drive(15, 4 * WIN + 200);

    // Fast then slow clocks.
    drive(12, 2 * WIN);
    drive(20, 2 * WIN + 100);

    // Densest pulse train: edges land on final gate and REPORT cycles.
    drive(2, 2 * WIN);

    // Reset mid-window.
    wait_mv(WIN + 10, 15);
    drive(15, 2000);
    rst_n = 1'b0;
    #1;
    chk_all_zero();
    drive(15, 3);
    rst_n = 1'b1;
    drive(15, WIN + 200);

    // Enable dropped for 10 cycles mid-window.
    wait_mv(WIN + 10, 15);
    drive(15, 1500);
    enable = 1'b0;
    drive(15, 10);
    enable = 1'b1;
    drive(15, WIN + 300);

    // Random clock rates with random stalls.
    repeat (2) begin
      rp = $urandom_range(2, 30);
      ph = $urandom_range(0, 29);
      drive(rp, $urandom_range(1000, 3000));
      drive(0, $urandom_range(0, 100));
    end

    drive(0, 5);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
